// File: rtl/sqrt_arb_pkg.sv
// Shared types and constants for the square-root unit arbiter.
package sqrt_arb_pkg;
   typedef enum logic [1:0] {IDLE, LOAD, WAIT, RESP} state_t;
   localparam int Q_W         = 16;
   localparam int R_W         = 17;
   localparam int TIMEOUT_DEF = 31;
endpackage

// File: rtl/sqrt_arbiter_rr_pick.sv
// Combinational round-robin priority encoder: first valid bit at or after ptr, wrapping.
module rr_pick #(
   parameter int N   = 4,
   parameter int IDW = 2
) (
   input  logic [N-1:0]   valid,
   input  logic [IDW-1:0] ptr,
   output logic [N-1:0]   grant,
   output logic [IDW-1:0] grant_id,
   output logic           found
);
   int idx;

   always_comb begin
      grant    = '0;
      grant_id = '0;
      found    = 1'b0;
      idx      = 0;
      for (int k = 0; k < N; k++) begin
         idx = (int'(ptr) + k) % N;
         if (!found && valid[idx]) begin
            found      = 1'b1;
            grant[idx] = 1'b1;
            grant_id   = IDW'(idx);
         end
      end
   end
endmodule

// File: rtl/sqrt_arbiter.sv
// Round-robin front end sharing one restoring square-root unit among N requesters,
// one request in flight, with a WAIT timeout that returns an error response.
module sqrt_arbiter
   import sqrt_arb_pkg::*;
#(
   parameter int N       = 4,
   parameter int IDW     = 2,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [N-1:0]      req_valid,
   input  logic [32*N-1:0]   req_d,
   output logic [N-1:0]      req_ready,
   output logic              rsp_valid,
   output logic [IDW-1:0]    rsp_id,
   output logic [Q_W-1:0]    rsp_q,
   output logic [R_W-1:0]    rsp_r,
   output logic              rsp_err,
   input  logic              rsp_ready,
   output logic [31:0]       sq_d,
   output logic              sq_load,
   output logic              sq_clrn,
   input  logic              sq_busy,
   input  logic              sq_ready,
   input  logic [Q_W-1:0]    sq_q,
   input  logic [R_W-1:0]    sq_r
);
   localparam int CW = $clog2(TIMEOUT + 1);

   state_t         state, state_nx;
   logic [IDW-1:0] ptr, id;
   logic [CW-1:0]  cnt;
   logic [N-1:0]   pick;
   logic [IDW-1:0] pick_id;
   logic           pick_any;
   logic           done, tmo;

   rr_pick #(.N(N), .IDW(IDW)) u_pick (
      .valid    (req_valid),
      .ptr      (ptr),
      .grant    (pick),
      .grant_id (pick_id),
      .found    (pick_any)
   );

   assign req_ready = (state == IDLE) ? pick : '0;
   assign sq_load   = (state == LOAD);
   // Completion wins over timeout when both land on the same cycle.
   assign done      = (state == WAIT) && sq_ready && !sq_busy;
   assign tmo       = (state == WAIT) && !done && (cnt == CW'(TIMEOUT - 1));

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (pick_any) state_nx = LOAD;
         LOAD:    state_nx = WAIT;
         WAIT:    if (done || tmo) state_nx = RESP;
         RESP:    if (rsp_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      sq_clrn <= ~rst;
      if (rst) begin
         state     <= IDLE;
         ptr       <= '0;
         id        <= '0;
         cnt       <= '0;
         sq_d      <= '0;
         rsp_valid <= 1'b0;
         rsp_id    <= '0;
         rsp_q     <= '0;
         rsp_r     <= '0;
         rsp_err   <= 1'b0;
      end else begin
         state <= state_nx;
         case (state)
            IDLE: if (pick_any) begin
               sq_d <= req_d[32*int'(pick_id) +: 32];
               id   <= pick_id;
            end
            LOAD: cnt <= '0;
            WAIT: begin
               if (done) begin
                  rsp_valid <= 1'b1;
                  rsp_id    <= id;
                  rsp_q     <= sq_q;
                  rsp_r     <= sq_r;
                  rsp_err   <= 1'b0;
               end else if (tmo) begin
                  rsp_valid <= 1'b1;
                  rsp_id    <= id;
                  rsp_q     <= '0;
                  rsp_r     <= '0;
                  rsp_err   <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            RESP: if (rsp_ready) begin
               rsp_valid <= 1'b0;
               ptr       <= (id == IDW'(N - 1)) ? '0 : id + 1'b1;
            end
            default: ;
         endcase
      end
   end
endmodule
